edf_arbiter: RTL and testbench

- Earliest-deadline-first selector for the interrupt controller.
- Takes the pending flags and absolute deadlines from NrSrc gateway cells and picks the pending source with the smallest deadline, scanning one source per cycle.
- Presents the winner to the core as irq/id/deadline. On core acknowledge, it pulses a one-hot claim back to that cell.

---
 rtl/edf_arbiter.sv | 97 +++++++++
 tb/tb_edf_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/edf_arbiter.sv
// edf_arbiter: earliest-deadline-first pending-source selector with one-hot claim pulse
module edf_arbiter #(
  parameter int NrSrc   = 8,
  parameter int TsWidth = 64,
  parameter int IdWidth = $clog2(NrSrc)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     en_i,
  input  logic [NrSrc-1:0]         ip_i,
  input  logic [NrSrc*TsWidth-1:0] dl_i,
  output logic                     irq_o,
  output logic [IdWidth-1:0]       irq_id_o,
  output logic [TsWidth-1:0]       irq_dl_o,
  input  logic                     irq_ack_i,
  output logic [NrSrc-1:0]         claim_o,
  output logic                     busy_o
);
  typedef enum logic [1:0] {IDLE, SCAN, PRESENT} state_e;
  state_e state_q, state_d;
  logic [NrSrc-1:0] snap_q, snap_d, claim_q, claim_d;
  logic [IdWidth-1:0] idx_q, idx_d, best_id_q, best_id_d, id_q, id_d;
  logic [TsWidth-1:0] best_dl_q, best_dl_d, dl_q, dl_d, cur_dl;
  logic found_q, found_d, take, last, hit;
  assign cur_dl = dl_i[idx_q*TsWidth +: TsWidth];
  assign take = ip_i[idx_q] && (!found_q || cur_dl < best_dl_q);
  assign last = idx_q == IdWidth'(NrSrc-1);
  assign hit = irq_ack_i && ip_i[id_q];
  always_comb begin
    state_d = state_q;
    snap_d = snap_q;
    idx_d = idx_q;
    found_d = found_q;
    best_id_d = best_id_q;
    best_dl_d = best_dl_q;
    id_d = id_q;
    dl_d = dl_q;
    claim_d = '0;
    if (!en_i) state_d = IDLE;
    else if (state_q == IDLE) begin
      if (|ip_i) begin
        state_d = SCAN;
        snap_d = ip_i;
        idx_d = '0;
        found_d = 1'b0;
      end
    end else if (state_q == SCAN) begin
      found_d = found_q | ip_i[idx_q];
      best_id_d = take ? idx_q : best_id_q;
      best_dl_d = take ? cur_dl : best_dl_q;
      idx_d = idx_q + 1'b1;
      if (last) begin
        state_d = found_d ? PRESENT : IDLE;
        id_d = found_d ? best_id_d : id_q;
        dl_d = found_d ? best_dl_d : dl_q;
      end
    end else if (state_q == PRESENT) begin
      if (hit) begin
        claim_d[id_q] = 1'b1;
        state_d = IDLE;
      end else if (ip_i != snap_q) begin
        state_d = SCAN;
        snap_d = ip_i;
        idx_d = '0;
        found_d = 1'b0;
      end
    end else state_d = IDLE;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      snap_q <= '0;
      idx_q <= '0;
      found_q <= 1'b0;
      best_id_q <= '0;
      best_dl_q <= '0;
      id_q <= '0;
      dl_q <= '0;
      claim_q <= '0;
    end else begin
      state_q <= state_d;
      snap_q <= snap_d;
      idx_q <= idx_d;
      found_q <= found_d;
      best_id_q <= best_id_d;
      best_dl_q <= best_dl_d;
      id_q <= id_d;
      dl_q <= dl_d;
      claim_q <= claim_d;
    end
  end
  assign irq_o = state_q == PRESENT;
  assign busy_o = state_q == SCAN;
  assign irq_id_o = id_q;
  assign irq_dl_o = dl_q;
  assign claim_o = claim_q;
endmodule

// File: tb/tb_edf_arbiter.sv
// tb_edf_arbiter: directed table-driven and sequence checks for edf_arbiter
module tb_edf_arbiter;
  logic clk_i = 1'b0, rst_ni = 1'b0, en_i = 1'b0, irq_ack_i = 1'b0;
  logic [7:0] ip_i = '0;
  logic [7:0][63:0] dl_i = '0;
  logic irq_o, busy_o;
  logic [2:0] irq_id_o;
  logic [63:0] irq_dl_o;
  logic [7:0] claim_o;
  int errors = 0, checks = 0;
  typedef struct packed {
    logic [7:0] ip;
    logic [7:0][63:0] d;
    logic [2:0] id;
    logic [63:0] edl;
  } vec_t;
  vec_t v [6];
  always #5 clk_i = ~clk_i;
  edf_arbiter #(.NrSrc(8), .TsWidth(64)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .ip_i(ip_i), .dl_i(dl_i),
    .irq_o(irq_o), .irq_id_o(irq_id_o), .irq_dl_o(irq_dl_o),
    .irq_ack_i(irq_ack_i), .claim_o(claim_o), .busy_o(busy_o)
  );
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic wait_irq(output int n);
    n = 0;
    while (!irq_o && n < 30) begin
      tick();
      n++;
    end
  endtask
  initial begin
    int n;
    logic [7:0] seen;
    v[0] = '0; v[0].ip = 8'b0010_0100; v[0].d[2] = 500; v[0].d[5] = 300; v[0].id = 5; v[0].edl = 300;
    v[1] = '0; v[1].ip = 8'b1000_0010; v[1].d[1] = 100; v[1].d[7] = 100; v[1].id = 1; v[1].edl = 100;
    v[2] = '0; v[2].ip = 8'hFF; v[2].id = 7; v[2].edl = 930;
    for (int k = 0; k < 8; k++) v[2].d[k] = 64'(1000 - k * 10);
    v[3] = '0; v[3].ip = 8'h01; v[3].d[0] = 64'hFFFF_FFFF_FFFF_FFFF; v[3].id = 0; v[3].edl = 64'hFFFF_FFFF_FFFF_FFFF;
    v[4] = '0; v[4].ip = 8'b0001_1000; v[4].d[3] = 64'h8000_0000_0000_0000; v[4].d[4] = 64'h7FFF_FFFF_FFFF_FFFF;
    v[4].id = 4; v[4].edl = 64'h7FFF_FFFF_FFFF_FFFF;
    v[5] = '0; v[5].ip = 8'hFF; v[5].id = 0; v[5].edl = 42;
    for (int k = 0; k < 8; k++) v[5].d[k] = 42;
    tick();
    tick();
    chk("rst_irq", irq_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_claim", claim_o, 0);
    chk("rst_id", irq_id_o, 0);
    chk("rst_dl", irq_dl_o, 0);
    rst_ni = 1'b1;
    en_i = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("idle_irq", irq_o, 0);
      chk("idle_claim", claim_o, 0);
      chk("idle_busy", busy_o, 0);
    end
    for (int i = 0; i < 6; i++) begin
      ip_i = v[i].ip;
      dl_i = v[i].d;
      tick();
      chk("vec_busy", busy_o, 1);
      chk("vec_irq_scan", irq_o, 0);
      n = 1;
      while (!irq_o && n < 30) begin
        tick();
        n++;
      end
      chk("vec_latency", 64'(n), 9);
      chk("vec_id", irq_id_o, v[i].id);
      chk("vec_dl", irq_dl_o, v[i].edl);
      irq_ack_i = 1'b1;
      tick();
      chk("vec_claim", claim_o, 8'(1) << v[i].id);
      chk("vec_irq_ack", irq_o, 0);
      irq_ack_i = 1'b0;
      ip_i = '0;
      tick();
      chk("vec_claim_clr", claim_o, 0);
      chk("vec_idle", busy_o, 0);
    end
    dl_i = '0;
    dl_i[3] = 1000;
    ip_i = 8'b0000_1000;
    wait_irq(n);
    chk("pre_id3", irq_id_o, 3);
    ip_i[6] = 1'b1;
    dl_i[6] = 200;
    tick();
    chk("pre_drop", irq_o, 0);
    chk("pre_busy", busy_o, 1);
    chk("pre_id_hold", irq_id_o, 3);
    seen = claim_o;
    n = 0;
    while (!irq_o && n < 30) begin
      tick();
      seen |= claim_o;
      n++;
    end
    chk("pre_rescan_len", 64'(n), 8);
    chk("pre_no_claim", seen, 0);
    chk("pre_id6", irq_id_o, 6);
    chk("pre_dl", irq_dl_o, 200);
    irq_ack_i = 1'b1;
    tick();
    chk("pre_claim6", claim_o, 8'h40);
    irq_ack_i = 1'b0;
    ip_i = '0;
    tick();
    chk("pre_claim_clr", claim_o, 0);
    dl_i = '0;
    dl_i[0] = 5;
    ip_i = 8'h01;
    wait_irq(n);
    chk("drop_present", irq_o, 1);
    irq_ack_i = 1'b1;
    ip_i = '0;
    tick();
    chk("drop_claim", claim_o, 0);
    chk("drop_irq", irq_o, 0);
    chk("drop_busy", busy_o, 1);
    irq_ack_i = 1'b0;
    seen = '0;
    n = 0;
    while (busy_o && n < 30) begin
      tick();
      seen |= claim_o;
      n++;
    end
    chk("drop_scan_len", 64'(n), 8);
    chk("drop_no_claim", seen, 0);
    chk("drop_irq_idle", irq_o, 0);
    dl_i[6] = 77;
    ip_i = 8'b0100_0000;
    wait_irq(n);
    chk("en_id", irq_id_o, 6);
    irq_ack_i = 1'b1;
    en_i = 1'b0;
    tick();
    chk("en_claim", claim_o, 0);
    chk("en_irq", irq_o, 0);
    chk("en_busy", busy_o, 0);
    irq_ack_i = 1'b0;
    tick();
    chk("en_hold_idle", busy_o, 0);
    chk("en_hold_claim", claim_o, 0);
    ip_i = '0;
    en_i = 1'b1;
    tick();
    dl_i[4] = 9;
    ip_i = 8'h10;
    tick();
    tick();
    irq_ack_i = 1'b1;
    tick();
    chk("scan_ack_claim", claim_o, 0);
    chk("scan_busy", busy_o, 1);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_irq", irq_o, 0);
    chk("arst_busy", busy_o, 0);
    chk("arst_claim", claim_o, 0);
    chk("arst_id", irq_id_o, 0);
    chk("arst_dl", irq_dl_o, 0);
    irq_ack_i = 1'b0;
    ip_i = '0;
    rst_ni = 1'b1;
    tick();
    chk("post_busy", busy_o, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
